// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bundle for regfile_wb_arbiter: two requester ports,
// each a valid/ready handshake carrying a destination register and data.
interface regfile_wb_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  wb0_valid;
    logic                  wb0_ready;
    logic [ADDR_WIDTH-1:0] wb0_addr;
    logic [DATA_WIDTH-1:0] wb0_data;

    logic                  wb1_valid;
    logic                  wb1_ready;
    logic [ADDR_WIDTH-1:0] wb1_addr;
    logic [DATA_WIDTH-1:0] wb1_data;

    // Requester side (EXU on port 0, LSU on port 1)
    modport master (
        output wb0_valid, wb0_addr, wb0_data,
        input  wb0_ready,
        output wb1_valid, wb1_addr, wb1_data,
        input  wb1_ready
    );

    // Arbiter side
    modport slave (
        input  wb0_valid, wb0_addr, wb0_data,
        output wb0_ready,
        input  wb1_valid, wb1_addr, wb1_data,
        output wb1_ready
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register file writeback arbiter: round-robin between EXU (port 0) and
// LSU (port 1), one-entry commit stage driving the regfile write port, and
// a per-register busy scoreboard for IDU RAW-hazard stalls.
// Optional: define REGFILE_WB_BYPASS_EN to add commit-stage bypass outputs
// (byp1/byp2) and mask busy for a register being committed this cycle.
module regfile_wb_arbiter #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    regfile_wb_arbiter_if.slave    wb,
    input  logic                   wb_stall,
    input  logic                   sb_set,
    input  logic [ADDR_WIDTH-1:0]  sb_set_addr,
    input  logic [ADDR_WIDTH-1:0]  qaddr1,
    input  logic [ADDR_WIDTH-1:0]  qaddr2,
    output logic                   busy1,
    output logic                   busy2,
    output logic                   rf_wen,
    output logic [ADDR_WIDTH-1:0]  rf_waddr,
    output logic [DATA_WIDTH-1:0]  rf_wdata
`ifdef REGFILE_WB_BYPASS_EN
    ,
    output logic                   byp1_hit,
    output logic [DATA_WIDTH-1:0]  byp1_data,
    output logic                   byp2_hit,
    output logic [DATA_WIDTH-1:0]  byp2_data
`endif
);

    localparam int unsigned NUM_REGS = 1 << ADDR_WIDTH;

    typedef enum logic {
        PRI_P0 = 1'b0,
        PRI_P1 = 1'b1
    } pri_e;

    pri_e                pri_q;
    pri_e                pri_d;
    logic                gnt0;
    logic                gnt1;
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Priority pointer register
    always_ff @(posedge clk) begin
        if (rst) begin
            pri_q <= PRI_P0;
        end else begin
            pri_q <= pri_d;
        end
    end

    // Grant selection and pointer update; pointer holds when nothing is granted
    always_comb begin
        gnt0  = 1'b0;
        gnt1  = 1'b0;
        pri_d = pri_q;
        if (!rst && !wb_stall) begin
            if (wb.wb0_valid && (!wb.wb1_valid || pri_q == PRI_P0)) begin
                gnt0 = 1'b1;
            end else if (wb.wb1_valid) begin
                gnt1 = 1'b1;
            end
        end
        if (gnt0) begin
            pri_d = PRI_P1;
        end else if (gnt1) begin
            pri_d = PRI_P0;
        end
    end

    assign wb.wb0_ready = gnt0;
    assign wb.wb1_ready = gnt1;

    // Commit stage: capture the granted write; x0 writes handshake but never enable
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (gnt0) begin
            rf_wen   <= (wb.wb0_addr != '0);
            rf_waddr <= wb.wb0_addr;
            rf_wdata <= wb.wb0_data;
        end else if (gnt1) begin
            rf_wen   <= (wb.wb1_addr != '0);
            rf_waddr <= wb.wb1_addr;
            rf_wdata <= wb.wb1_data;
        end else begin
            rf_wen   <= 1'b0;
        end
    end

    // Scoreboard next state: commit clears, issue sets (set wins), x0 never busy
    always_comb begin
        busy_d = busy_q;
        if (rf_wen) begin
            busy_d[rf_waddr] = 1'b0;
        end
        if (sb_set && sb_set_addr != '0) begin
            busy_d[sb_set_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

`ifdef REGFILE_WB_BYPASS_EN
    // Hazard query with commit-stage forwarding
    always_comb begin
        byp1_hit  = rf_wen && (rf_waddr == qaddr1) && (qaddr1 != '0);
        byp2_hit  = rf_wen && (rf_waddr == qaddr2) && (qaddr2 != '0);
        byp1_data = rf_wdata;
        byp2_data = rf_wdata;
        busy1     = busy_q[qaddr1] && !byp1_hit;
        busy2     = busy_q[qaddr2] && !byp2_hit;
    end
`else
    // Hazard query straight from the scoreboard
    always_comb begin
        busy1 = busy_q[qaddr1];
        busy2 = busy_q[qaddr2];
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: table of per-cycle vectors with expected
// ready and expected commit, commits checked through a queue one cycle later;
// hand-written sequences cover the scoreboard and reset corner cases.
module tb_regfile_wb_arbiter;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

    typedef struct {
        logic          v0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          v1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic          stall;
        logic          r;
        logic          sbs;
        logic [AW-1:0] sba;
        logic          er0;
        logic          er1;
        logic          ewen;
        logic [AW-1:0] ewa;
        logic [DW-1:0] ewd;
    } vec_t;

    typedef struct {
        logic          wen;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } commit_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wb_stall = 1'b0;
    logic          sb_set = 1'b0;
    logic [AW-1:0] sb_set_addr = '0;
    logic [AW-1:0] qaddr1 = '0;
    logic [AW-1:0] qaddr2 = '0;
    logic          busy1;
    logic          busy2;
    logic          rf_wen;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
`ifdef REGFILE_WB_BYPASS_EN
    logic          byp1_hit;
    logic [DW-1:0] byp1_data;
    logic          byp2_hit;
    logic [DW-1:0] byp2_data;
`endif

    int errors = 0;
    int checks = 0;
    commit_t exp_q[$];
    vec_t    tbl[$];

    regfile_wb_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) wb_if ();

    regfile_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .wb          (wb_if),
        .wb_stall    (wb_stall),
        .sb_set      (sb_set),
        .sb_set_addr (sb_set_addr),
        .qaddr1      (qaddr1),
        .qaddr2      (qaddr2),
        .busy1       (busy1),
        .busy2       (busy2),
        .rf_wen      (rf_wen),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata)
`ifdef REGFILE_WB_BYPASS_EN
        ,
        .byp1_hit    (byp1_hit),
        .byp1_data   (byp1_data),
        .byp2_hit    (byp2_hit),
        .byp2_data   (byp2_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(
        input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
        input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
        input logic stall, input logic r, input logic sbs, input logic [AW-1:0] sba,
        input logic er0, input logic er1,
        input logic ewen, input logic [AW-1:0] ewa, input logic [DW-1:0] ewd);
        vec_t v;
        v.v0 = v0; v.a0 = a0; v.d0 = d0;
        v.v1 = v1; v.a1 = a1; v.d1 = d1;
        v.stall = stall; v.r = r; v.sbs = sbs; v.sba = sba;
        v.er0 = er0; v.er1 = er1;
        v.ewen = ewen; v.ewa = ewa; v.ewd = ewd;
        return v;
    endfunction

    // One clock cycle: drive, check ready before the edge, check commit after it
    task automatic run(input vec_t v);
        commit_t c;
        commit_t e;
        @(negedge clk);
        rst              = v.r;
        wb_if.wb0_valid  = v.v0;
        wb_if.wb0_addr   = v.a0;
        wb_if.wb0_data   = v.d0;
        wb_if.wb1_valid  = v.v1;
        wb_if.wb1_addr   = v.a1;
        wb_if.wb1_data   = v.d1;
        wb_stall         = v.stall;
        sb_set           = v.sbs;
        sb_set_addr      = v.sba;
        #1;
        chk("wb0_ready", 64'(wb_if.wb0_ready), 64'(v.er0));
        chk("wb1_ready", 64'(wb_if.wb1_ready), 64'(v.er1));
        c.wen = v.ewen;
        c.a   = v.ewa;
        c.d   = v.ewd;
        exp_q.push_back(c);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("rf_wen", 64'(rf_wen), 64'(e.wen));
        if (e.wen) begin
            chk("rf_waddr", 64'(rf_waddr), 64'(e.a));
            chk("rf_wdata", 64'(rf_wdata), 64'(e.d));
        end
    endtask

    function automatic vec_t idle();
        return mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0,
                  1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    endfunction

    function automatic vec_t sbset(input logic [AW-1:0] a);
        return mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, a,
                  1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    endfunction

    function automatic vec_t wr1(input logic [AW-1:0] a, input logic [DW-1:0] d);
        return mk(1'b0, 5'd0, 32'd0, 1'b1, a, d, 1'b0, 1'b0, 1'b0, 5'd0,
                  1'b0, 1'b1, 1'b1, a, d);
    endfunction

    initial begin
        wb_if.wb0_valid = 1'b0;
        wb_if.wb0_addr  = '0;
        wb_if.wb0_data  = '0;
        wb_if.wb1_valid = 1'b0;
        wb_if.wb1_addr  = '0;
        wb_if.wb1_data  = '0;

        // Reset with requests present: nothing accepted, outputs cleared
        qaddr1 = 5'd5;
        qaddr2 = 5'd7;
        repeat (2) run(mk(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd7, 32'h1, 1'b0, 1'b1, 1'b1, 5'd5,
                          1'b0, 1'b0, 1'b0, 5'd0, 32'd0));
        chk("rst_waddr", 64'(rf_waddr), 64'd0);
        chk("rst_wdata", 64'(rf_wdata), 64'd0);
        chk("rst_busy1", 64'(busy1), 64'd0);
        chk("rst_busy2", 64'(busy2), 64'd0);

        // Arbitration vectors
        tbl.push_back(mk(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0,
                         1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF));
        tbl.push_back(idle());
        tbl.push_back(wr1(5'd12, 32'h0000_1111));
        for (int i = 0; i < 2; i++) begin
            tbl.push_back(mk(1'b1, 5'd3, 32'hA0A0_0003, 1'b1, 5'd7, 32'hB1B1_0007, 1'b0, 1'b0, 1'b0, 5'd0,
                             1'b1, 1'b0, 1'b1, 5'd3, 32'hA0A0_0003));
            tbl.push_back(mk(1'b1, 5'd3, 32'hA0A0_0003, 1'b1, 5'd7, 32'hB1B1_0007, 1'b0, 1'b0, 1'b0, 5'd0,
                             1'b0, 1'b1, 1'b1, 5'd7, 32'hB1B1_0007));
        end
        tbl.push_back(mk(1'b1, 5'd0, 32'h0000_1234, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0,
                         1'b1, 1'b0, 1'b0, 5'd0, 32'd0));
        tbl.push_back(mk(1'b1, 5'd2, 32'h0000_0022, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0,
                         1'b1, 1'b0, 1'b1, 5'd2, 32'h0000_0022));
        tbl.push_back(wr1(5'd4, 32'h0000_0044));
        for (int i = 0; i < 3; i++) begin
            tbl.push_back(mk(1'b1, 5'd3, 32'hA0A0_0003, 1'b1, 5'd7, 32'hB1B1_0007, 1'b1, 1'b0, 1'b0, 5'd0,
                             1'b0, 1'b0, 1'b0, 5'd0, 32'd0));
        end
        tbl.push_back(mk(1'b1, 5'd3, 32'hA0A0_0003, 1'b1, 5'd7, 32'hB1B1_0007, 1'b0, 1'b0, 1'b0, 5'd0,
                         1'b1, 1'b0, 1'b1, 5'd3, 32'hA0A0_0003));
        tbl.push_back(mk(1'b1, 5'd3, 32'hA0A0_0003, 1'b1, 5'd7, 32'hB1B1_0007, 1'b0, 1'b0, 1'b0, 5'd0,
                         1'b0, 1'b1, 1'b1, 5'd7, 32'hB1B1_0007));
        tbl.push_back(idle());
        qaddr1 = 5'd0;
        for (int i = 0; i < tbl.size(); i++) begin
            run(tbl[i]);
            chk("x0_busy1", 64'(busy1), 64'd0);
        end

        // Scoreboard set, commit clear, same-edge set wins
        qaddr1 = 5'd9;
        qaddr2 = 5'd17;
        run(sbset(5'd9));
        chk("sb_set_busy1", 64'(busy1), 64'd1);
        chk("sb_set_busy2", 64'(busy2), 64'd0);
        run(wr1(5'd9, 32'h0000_0099));
`ifdef REGFILE_WB_BYPASS_EN
        chk("commit_busy1", 64'(busy1), 64'd0);
        chk("byp1_hit", 64'(byp1_hit), 64'd1);
        chk("byp1_data", 64'(byp1_data), 64'h99);
        chk("byp2_hit", 64'(byp2_hit), 64'd0);
`else
        chk("commit_busy1", 64'(busy1), 64'd1);
`endif
        run(idle());
        chk("cleared_busy1", 64'(busy1), 64'd0);
        run(sbset(5'd9));
        chk("reset_busy1", 64'(busy1), 64'd1);
        run(wr1(5'd9, 32'h0000_0055));
        run(sbset(5'd9));
        chk("set_wins_busy1", 64'(busy1), 64'd1);
        run(wr1(5'd9, 32'h0000_0077));
        run(idle());
        chk("final_busy1", 64'(busy1), 64'd0);
        qaddr1 = 5'd0;
        run(sbset(5'd0));
        chk("x0_set_busy1", 64'(busy1), 64'd0);
        run(mk(1'b1, 5'd0, 32'h0000_1234, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0,
               1'b1, 1'b0, 1'b0, 5'd0, 32'd0));
        chk("x0_wr_busy1", 64'(busy1), 64'd0);
        run(sbset(5'd17));
        chk("busy2_17", 64'(busy2), 64'd1);

        // Reset in the cycle after an accept discards the staged write
        qaddr1 = 5'd6;
        qaddr2 = 5'd20;
        run(sbset(5'd20));
        chk("busy2_20", 64'(busy2), 64'd1);
        run(mk(1'b1, 5'd6, 32'h0000_0066, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0,
               1'b1, 1'b0, 1'b1, 5'd6, 32'h0000_0066));
        chk("staged_busy1", 64'(busy1), 64'd0);
`ifdef REGFILE_WB_BYPASS_EN
        chk("staged_byp1_hit", 64'(byp1_hit), 64'd1);
        chk("staged_byp1_data", 64'(byp1_data), 64'h66);
`endif
        run(mk(1'b1, 5'd6, 32'h0000_0067, 1'b1, 5'd8, 32'h0000_0088, 1'b0, 1'b1, 1'b0, 5'd0,
               1'b0, 1'b0, 1'b0, 5'd0, 32'd0));
        chk("mid_rst_busy2", 64'(busy2), 64'd0);
        chk("mid_rst_waddr", 64'(rf_waddr), 64'd0);
        chk("mid_rst_wdata", 64'(rf_wdata), 64'd0);
        qaddr2 = 5'd17;
        #1;
        chk("mid_rst_busy17", 64'(busy2), 64'd0);
        run(mk(1'b1, 5'd3, 32'hA0A0_0003, 1'b1, 5'd7, 32'hB1B1_0007, 1'b0, 1'b0, 1'b0, 5'd0,
               1'b1, 1'b0, 1'b1, 5'd3, 32'hA0A0_0003));
        run(idle());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Sequences the single write port of the integer register file.
- Arbitrates two writeback requesters: port 0 (EXU/ALU result) and port 1 (LSU load data).
- Registers the granted write into a one-entry commit stage that drives the register file write port.
- Keeps a per-register busy scoreboard so the IDU can stall on RAW hazards against in-flight producers.

Parameters:
- ADDR_WIDTH, 5, register index width; scoreboard has 2**ADDR_WIDTH entries.
- DATA_WIDTH, 32, register data width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- wb0_valid  in  1  port 0 write request
- wb0_ready  out  1  port 0 accepted this cycle
- wb0_addr  in  ADDR_WIDTH  port 0 destination register
- wb0_data  in  DATA_WIDTH  port 0 write data
- wb1_valid, wb1_ready, wb1_addr, wb1_data: same as port 0, for port 1
- wb_stall  in  1  blocks all acceptance (difftest step / debug halt)
- sb_set  in  1  IDU issues an instruction with a destination register
- sb_set_addr  in  ADDR_WIDTH  destination register of the issued instruction
- qaddr1  in  ADDR_WIDTH  hazard query address 1
- qaddr2  in  ADDR_WIDTH  hazard query address 2
- busy1  out  1  qaddr1 has a pending producer
- busy2  out  1  qaddr2 has a pending producer
- rf_wen  out  1  register file write enable
- rf_waddr  out  ADDR_WIDTH  register file write address
- rf_wdata  out  DATA_WIDTH  register file write data

Behaviour:
- Reset, synchronous, active-high:
  - rf_wen=0, rf_waddr=0, rf_wdata=0.
  - Commit stage invalid; all busy bits cleared; priority pointer = port 0.
  - Reset mid-operation discards any staged write: no rf_wen in the cycle after reset.
- Ready/handshake:
  - Handshake on wbN_valid & wbN_ready at posedge.
  - wbN_ready is combinational. It is 0 when wb_stall or rst. Otherwise it is 1 only for the granted port.
  - The commit stage drains every cycle, so there is no other backpressure.
- Arbitration:
  - Exactly one valid port: that port is granted.
  - Both ports valid: grant the port named by the priority pointer.
  - After any grant to port k, the pointer moves to the other port (round-robin).
  - The pointer does not change when nothing is granted.
- Latency:
  - Request accepted at edge T: rf_wen=1 with the captured address and data during cycle T+1.
  - The register file updates at edge T+2.
  - rf_wen=0 in every cycle without a staged write.
- x0 writes:
  - An accepted request with addr 0 completes the handshake normally.
  - The commit stage holds rf_wen=0 for it.
- Scoreboard:
  - busy[a] is set at the edge where sb_set=1, for a=sb_set_addr when a!=0.
  - busy[a] is cleared at the edge that ends a cycle with rf_wen=1 and rf_waddr=a.
  - Set and clear of the same register at the same edge: set wins.
  - busy[0] is always 0.
  - busy1 = busy[qaddr1] and busy2 = busy[qaddr2], both combinational from the registered bits.
- The block does not count multiple outstanding producers of one register. The IDU guarantees at most one per register.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined:
  - Adds outputs byp1_hit/byp1_data and byp2_hit/byp2_data.
  - bypN_hit = rf_wen & (rf_waddr==qaddrN) & (qaddrN!=0).
  - bypN_data = rf_wdata.
  - busyN is masked to 0 when bypN_hit, so a consumer can issue in the commit cycle.
- Undefined:
  - These ports do not exist.
  - busyN stays asserted through the commit cycle.

Test Plan:
- Reset, then wb0 writes addr=5 data=0xDEADBEEF:
  - wb0_ready=1 at T.
  - rf_wen=1, waddr=5, wdata=0xDEADBEEF at T+1.
  - rf_wen=0 at T+2.
- wb0 and wb1 both valid for 4 cycles (addrs 3, 7):
  - Grants are 0,1,0,1.
  - rf_waddr sequence is 3,7,3,7, each one cycle after its grant.
- sb_set addr=9, query qaddr1=9:
  - busy1=1 until a wb1 write to 9 commits.
  - busy1=0 after the commit edge.
  - Same-edge sb_set=9 with commit to 9: busy1 stays 1.
- wb0 write addr=0 data=0x1234:
  - wb0_ready=1.
  - rf_wen stays 0.
  - busy1 for qaddr1=0 stays 0.
- wb_stall=1 with both ports valid:
  - Both ready=0; priority pointer unchanged.
  - Release stall: port 0 is granted first.
- Assert rst in the cycle after an accept:
  - No rf_wen next cycle.
  - All busy=0.
  - With REGFILE_WB_BYPASS_EN: query matching a staged write gives byp1_hit=1 and correct byp1_data.
